// File: rtl/stage_ctrl_writer.sv
`default_nettype none
// ============================================================================
// stage_ctrl_writer: deserialises framed control commands for one RMT stage
// and issues single-cycle write strobes into its offset, TCAM and action tables.
// Revision: 1.0
// ============================================================================
module stage_ctrl_writer #(
   parameter int STAGE   = 0,
   parameter int KEY_LEN = 197,
   parameter int ACT_LEN = 25,
   parameter int KEY_OFF = 18,
   parameter int ADDR_W  = 4,
   parameter int C_W     = 64
) (
   input  logic                  axis_clk,
   input  logic                  aresetn,
   input  logic [C_W-1:0]        ctrl_data,
   input  logic                  ctrl_valid,
   input  logic                  ctrl_last,
   output logic                  ctrl_ready,
   output logic [KEY_OFF-1:0]    key_offset_out,
   output logic                  key_offset_valid_out,
   output logic [KEY_LEN-1:0]    lookup_din,
   output logic [KEY_LEN-1:0]    lookup_din_mask,
   output logic [ADDR_W-1:0]     lookup_din_addr,
   output logic                  lookup_din_en,
   output logic [ACT_LEN*25-1:0] action_data_in,
   output logic [ADDR_W-1:0]     action_addr,
   output logic                  action_en,
   output logic                  ctrl_err,
   output logic [7:0]            err_cnt
);

   localparam int ACT_W  = ACT_LEN * 25;
   localparam int NB_K   = (KEY_OFF + C_W - 1) / C_W;
   localparam int NB_L   = (KEY_LEN + C_W - 1) / C_W;
   localparam int NB_A   = (ACT_W + C_W - 1) / C_W;
   localparam int NB_MAX = (2 * NB_L > NB_A) ? 2 * NB_L : NB_A;
   localparam int ASM_W  = NB_MAX * C_W;
   localparam int CNT_W  = $clog2(NB_MAX + 1);

   localparam logic [1:0] TYPE_KEY = 2'd0;
   localparam logic [1:0] TYPE_LKP = 2'd1;
   localparam logic [1:0] TYPE_ACT = 2'd2;
   localparam logic [1:0] TYPE_RSV = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DISCARD = 2'd2,
      ST_WRITE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         type_q, type_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc, exp_cnt;
   logic [ASM_W-1:0]   asm_q, asm_d;
   logic               ready_q, ready_d;
   logic [KEY_OFF-1:0] key_offset_q, key_offset_d;
   logic               key_offset_en_q, key_offset_en_d;
   logic [KEY_LEN-1:0] lookup_q, lookup_d;
   logic [KEY_LEN-1:0] lookup_mask_q, lookup_mask_d;
   logic [ADDR_W-1:0]  lookup_addr_q, lookup_addr_d;
   logic               lookup_en_q, lookup_en_d;
   logic [ACT_W-1:0]   action_q, action_d;
   logic [ADDR_W-1:0]  action_addr_q, action_addr_d;
   logic               action_en_q, action_en_d;
   logic               err_q, err_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               accept;

   assign accept  = ctrl_valid & ready_q;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      exp_cnt = CNT_W'(NB_A);
      case (type_q)
         TYPE_KEY: exp_cnt = CNT_W'(NB_K);
         TYPE_LKP: exp_cnt = CNT_W'(2 * NB_L);
         default:  exp_cnt = CNT_W'(NB_A);
      endcase
   end

   always_comb begin
      state_d         = state_q;
      type_d          = type_q;
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      asm_d           = asm_q;
      err_d           = 1'b0;
      key_offset_d    = key_offset_q;
      key_offset_en_d = 1'b0;
      lookup_d        = lookup_q;
      lookup_mask_d   = lookup_mask_q;
      lookup_addr_d   = lookup_addr_q;
      lookup_en_d     = 1'b0;
      action_d        = action_q;
      action_addr_d   = action_addr_q;
      action_en_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               type_d = ctrl_data[1:0];
               addr_d = ctrl_data[4+ADDR_W:5];
               cnt_d  = '0;
               // A header-only frame is malformed even when aimed at another stage.
               if (ctrl_last) begin
                  err_d = 1'b1;
               end else if (ctrl_data[4:2] != 3'(STAGE)) begin
                  state_d = ST_DISCARD;
               end else if (ctrl_data[1:0] == TYPE_RSV) begin
                  state_d = ST_DISCARD;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (accept) begin
               for (int b = 0; b < NB_MAX; b++) begin
                  if (cnt_q == CNT_W'(b)) asm_d[b*C_W +: C_W] = ctrl_data;
               end
               cnt_d = cnt_inc;
               if (ctrl_last) begin
                  if (cnt_inc == exp_cnt) begin
                     state_d = ST_WRITE;
                     // Load from asm_d so the final beat lands in the same edge.
                     case (type_q)
                        TYPE_KEY: begin
                           key_offset_d    = asm_d[KEY_OFF-1:0];
                           key_offset_en_d = 1'b1;
                        end
                        TYPE_LKP: begin
                           lookup_d      = asm_d[KEY_LEN-1:0];
                           lookup_mask_d = asm_d[NB_L*C_W +: KEY_LEN];
                           lookup_addr_d = addr_q;
                           lookup_en_d   = 1'b1;
                        end
                        default: begin
                           action_d      = asm_d[ACT_W-1:0];
                           action_addr_d = addr_q;
                           action_en_d   = 1'b1;
                        end
                     endcase
                  end else begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end
               end else if (cnt_inc == exp_cnt) begin
                  state_d = ST_DISCARD;
                  err_d   = 1'b1;
               end
            end
         end
         ST_DISCARD: begin
            if (accept && ctrl_last) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d   = (state_d != ST_WRITE);
      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q         <= ST_IDLE;
         type_q          <= '0;
         addr_q          <= '0;
         cnt_q           <= '0;
         asm_q           <= '0;
         ready_q         <= 1'b0;
         key_offset_q    <= '0;
         key_offset_en_q <= 1'b0;
         lookup_q        <= '0;
         lookup_mask_q   <= '0;
         lookup_addr_q   <= '0;
         lookup_en_q     <= 1'b0;
         action_q        <= '0;
         action_addr_q   <= '0;
         action_en_q     <= 1'b0;
         err_q           <= 1'b0;
         err_cnt_q       <= '0;
      end else begin
         state_q         <= state_d;
         type_q          <= type_d;
         addr_q          <= addr_d;
         cnt_q           <= cnt_d;
         asm_q           <= asm_d;
         ready_q         <= ready_d;
         key_offset_q    <= key_offset_d;
         key_offset_en_q <= key_offset_en_d;
         lookup_q        <= lookup_d;
         lookup_mask_q   <= lookup_mask_d;
         lookup_addr_q   <= lookup_addr_d;
         lookup_en_q     <= lookup_en_d;
         action_q        <= action_d;
         action_addr_q   <= action_addr_d;
         action_en_q     <= action_en_d;
         err_q           <= err_d;
         err_cnt_q       <= err_cnt_d;
      end
   end

   assign ctrl_ready           = ready_q;
   assign key_offset_out       = key_offset_q;
   assign key_offset_valid_out = key_offset_en_q;
   assign lookup_din           = lookup_q;
   assign lookup_din_mask      = lookup_mask_q;
   assign lookup_din_addr      = lookup_addr_q;
   assign lookup_din_en        = lookup_en_q;
   assign action_data_in       = action_q;
   assign action_addr          = action_addr_q;
   assign action_en            = action_en_q;
   assign ctrl_err             = err_q;
   assign err_cnt              = err_cnt_q;

endmodule

`default_nettype wire
